// File: rtl/tdc_sample_accum_if.sv
// rtl/tdc_sample_accum_if.sv - sample stream in and batch result out of the TDC accumulator
interface tdc_sample_accum_if #(
    parameter int HW_W         = 7,
    parameter int LOG2_SAMPLES = 4
);
    localparam int SUM_W = HW_W + LOG2_SAMPLES;

    logic             val_in;
    logic [HW_W-1:0]  hw_in;
    logic             out_rdy;
    logic             out_val;
    logic [SUM_W-1:0] sum_out;
    logic [HW_W-1:0]  avg_out;
    logic [HW_W-1:0]  min_out;
    logic [HW_W-1:0]  max_out;

    modport master (
        output val_in, hw_in, out_rdy,
        input  out_val, sum_out, avg_out, min_out, max_out
    );

    modport slave (
        input  val_in, hw_in, out_rdy,
        output out_val, sum_out, avg_out, min_out, max_out
    );
endinterface

// File: rtl/tdc_sample_accum.sv
// rtl/tdc_sample_accum.sv - batch sum/avg/min/max of TDC pop-count samples with held result
module tdc_sample_accum #(
    parameter int HW_W         = 7,
    parameter int LOG2_SAMPLES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                start,
    output logic                busy,
    output logic                ovr,
    tdc_sample_accum_if.slave   bus
);
    localparam int SUM_W = HW_W + LOG2_SAMPLES;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [SUM_W-1:0]        sum_acc;
    logic [LOG2_SAMPLES-1:0] count_q;
    logic [HW_W-1:0]         min_acc, max_acc;
    logic [SUM_W-1:0]        sum_q;
    logic [HW_W-1:0]         min_q, max_q;
    logic                    ovr_q;

    logic                    clear_acc, take_sample, load_out, ovr_set;
    logic                    sample_seen;
    logic [SUM_W-1:0]        sum_nxt;
    logic [HW_W-1:0]         min_nxt, max_nxt;

    assign sample_seen = en && bus.val_in;
    assign sum_nxt     = sum_acc + {{LOG2_SAMPLES{1'b0}}, bus.hw_in};
    assign min_nxt     = (bus.hw_in < min_acc) ? bus.hw_in : min_acc;
    assign max_nxt     = (bus.hw_in > max_acc) ? bus.hw_in : max_acc;

    always_comb begin
        state_d     = state_q;
        clear_acc   = 1'b0;
        take_sample = 1'b0;
        load_out    = 1'b0;
        ovr_set     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = ACCUM;
                    clear_acc = 1'b1;
                end
            end
            ACCUM: begin
                // A restart discards any sample arriving in the same cycle.
                if (start) begin
                    clear_acc = 1'b1;
                end else if (sample_seen) begin
                    take_sample = 1'b1;
                    if (count_q == '1) begin
                        load_out = 1'b1;
                        state_d  = HOLD;
                    end
                end
            end
            HOLD: begin
                ovr_set = sample_seen;
                if (bus.out_rdy) begin
                    if (start) begin
                        state_d   = ACCUM;
                        clear_acc = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sum_acc <= '0;
            count_q <= '0;
            min_acc <= '1;
            max_acc <= '0;
            sum_q   <= '0;
            min_q   <= '0;
            max_q   <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (clear_acc) begin
                sum_acc <= '0;
                count_q <= '0;
                min_acc <= '1;
                max_acc <= '0;
                ovr_q   <= 1'b0;
            end else begin
                if (take_sample) begin
                    sum_acc <= sum_nxt;
                    count_q <= count_q + 1'b1;
                    min_acc <= min_nxt;
                    max_acc <= max_nxt;
                end
                if (ovr_set) begin
                    ovr_q <= 1'b1;
                end
            end
            // Result registers change only when a batch completes, so the
            // previous batch stays readable after the handshake.
            if (load_out) begin
                sum_q <= sum_nxt;
                min_q <= min_nxt;
                max_q <= max_nxt;
            end
        end
    end

    assign busy        = (state_q == ACCUM);
    assign ovr         = ovr_q;
    assign bus.out_val = (state_q == HOLD);
    assign bus.sum_out = sum_q;
    assign bus.avg_out = sum_q[SUM_W-1:LOG2_SAMPLES];
    assign bus.min_out = min_q;
    assign bus.max_out = max_q;
endmodule

// File: tb/tb_tdc_sample_accum.sv
// tb/tb_tdc_sample_accum.sv - self-checking bench for tdc_sample_accum
module tb_tdc_sample_accum;
    localparam int HW_W  = 7;
    localparam int L     = 4;
    localparam int NSAMP = 1 << L;

    logic clk, rst, en, start, busy, ovr;
    int   checks = 0;
    int   errors = 0;

    tdc_sample_accum_if #(.HW_W(HW_W), .LOG2_SAMPLES(L)) bus ();

    tdc_sample_accum #(.HW_W(HW_W), .LOG2_SAMPLES(L)) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .start (start),
        .busy  (busy),
        .ovr   (ovr),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Transaction-level reference: a batch is the list of accepted samples.
    bit m_held, m_active, m_ovr;
    int m_sum, m_min, m_max;
    int q[$];

    task automatic model_step();
        bit smp;
        smp = en && bus.val_in;
        if (rst) begin
            m_held = 0; m_active = 0; m_ovr = 0;
            m_sum = 0; m_min = 0; m_max = 0;
            q.delete();
        end else if (m_held) begin
            if (smp) m_ovr = 1;
            if (bus.out_rdy) begin
                m_held = 0;
                if (start) begin
                    m_active = 1; m_ovr = 0; q.delete();
                end
            end
        end else if (m_active) begin
            if (start) begin
                q.delete();
            end else if (smp) begin
                q.push_back(int'(bus.hw_in));
                if (q.size() == NSAMP) begin
                    m_sum = 0; m_min = 1 << HW_W; m_max = 0;
                    foreach (q[k]) begin
                        m_sum += q[k];
                        if (q[k] < m_min) m_min = q[k];
                        if (q[k] > m_max) m_max = q[k];
                    end
                    m_held = 1; m_active = 0;
                    q.delete();
                end
            end
        end else if (start) begin
            m_active = 1; m_ovr = 0; q.delete();
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        check("out_val", 32'(bus.out_val), 32'(m_held));
        check("busy",    32'(busy),        32'(m_active));
        check("ovr",     32'(ovr),         32'(m_ovr));
        check("sum_out", 32'(bus.sum_out), 32'(m_sum));
        check("avg_out", 32'(bus.avg_out), 32'(m_sum / NSAMP));
        check("min_out", 32'(bus.min_out), 32'(m_min));
        check("max_out", 32'(bus.max_out), 32'(m_max));
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic feed(input int hw);
        en = 1; bus.val_in = 1; bus.hw_in = HW_W'(hw);
        tick();
        bus.val_in = 0;
    endtask

    task automatic pulse_start();
        start = 1;
        tick();
        start = 0;
    endtask

    typedef struct {
        int pre;       // samples of 64 fed before the restart pulse
        int first;
        int step;
        int gap;       // stall cycles before each sample
        bit hold_ovr;  // hold result under backpressure with dropped samples
        int exp_sum, exp_avg, exp_min, exp_max;
    } batch_vec_t;

    batch_vec_t vecs[6];

    task automatic run_batch(input batch_vec_t v);
        if (v.pre > 0) begin
            pulse_start();
            for (int i = 0; i < v.pre; i++) feed(64);
        end
        pulse_start();
        check("busy_after_start", 32'(busy), 32'd1);
        for (int i = 0; i < NSAMP; i++) begin
            for (int g = 0; g < v.gap; g++) begin
                en = (g % 2) != 0; bus.val_in = (g % 2) == 0;
                bus.hw_in = 7'h55;
                tick();
                check("busy_in_gap", 32'(busy), 32'd1);
            end
            en = 1; bus.val_in = 0;
            feed(v.first + i * v.step);
        end
        check("batch_out_val", 32'(bus.out_val), 32'd1);
        check("batch_sum", 32'(bus.sum_out), 32'(v.exp_sum));
        check("batch_avg", 32'(bus.avg_out), 32'(v.exp_avg));
        check("batch_min", 32'(bus.min_out), 32'(v.exp_min));
        check("batch_max", 32'(bus.max_out), 32'(v.exp_max));
        if (v.hold_ovr) begin
            for (int c = 0; c < 10; c++) begin
                en = 1; bus.val_in = (c % 3) == 1; bus.hw_in = 7'd3;
                tick();
            end
            bus.val_in = 0;
            check("hold_ovr", 32'(ovr), 32'd1);
            check("hold_sum_stable", 32'(bus.sum_out), 32'(v.exp_sum));
            bus.out_rdy = 1; start = 1;
            tick();
            bus.out_rdy = 0; start = 0;
            check("restart_busy", 32'(busy), 32'd1);
            check("restart_ovr", 32'(ovr), 32'd0);
            check("restart_out_val", 32'(bus.out_val), 32'd0);
        end else begin
            bus.out_rdy = 1;
            tick();
            bus.out_rdy = 0;
            check("done_out_val", 32'(bus.out_val), 32'd0);
            check("done_busy", 32'(busy), 32'd0);
            check("kept_sum", 32'(bus.sum_out), 32'(v.exp_sum));
        end
    endtask

    initial begin
        vecs[0] = '{pre:0, first:0,   step:1,  gap:0, hold_ovr:0, exp_sum:120,  exp_avg:7,   exp_min:0,   exp_max:15};
        vecs[1] = '{pre:0, first:32,  step:0,  gap:2, hold_ovr:0, exp_sum:512,  exp_avg:32,  exp_min:32,  exp_max:32};
        vecs[2] = '{pre:0, first:100, step:-5, gap:0, hold_ovr:1, exp_sum:1000, exp_avg:62,  exp_min:25,  exp_max:100};
        vecs[3] = '{pre:7, first:1,   step:0,  gap:0, hold_ovr:0, exp_sum:16,   exp_avg:1,   exp_min:1,   exp_max:1};
        vecs[4] = '{pre:0, first:127, step:0,  gap:1, hold_ovr:0, exp_sum:2032, exp_avg:127, exp_min:127, exp_max:127};
        vecs[5] = '{pre:0, first:0,   step:0,  gap:0, hold_ovr:0, exp_sum:0,    exp_avg:0,   exp_min:0,   exp_max:0};

        rst = 1; en = 0; start = 0;
        bus.val_in = 0; bus.hw_in = '0; bus.out_rdy = 0;
        tick();
        tick();
        rst = 0;
        check("reset_out_val", 32'(bus.out_val), 32'd0);
        check("reset_sum", 32'(bus.sum_out), 32'd0);

        for (int i = 0; i < 3; i++) feed(9);
        check("idle_ovr", 32'(ovr), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);

        for (int i = 0; i < 6; i++) run_batch(vecs[i]);

        pulse_start();
        for (int i = 0; i < 5; i++) feed(50);
        rst = 1;
        tick();
        rst = 0;
        check("midreset_busy", 32'(busy), 32'd0);
        check("midreset_sum", 32'(bus.sum_out), 32'd0);
        check("midreset_max", 32'(bus.max_out), 32'd0);
        run_batch(vecs[4]);

        for (int c = 0; c < 4000; c++) begin
            rst        = ($urandom_range(499) == 0);
            start      = ($urandom_range(39) == 0);
            en         = ($urandom_range(9) < 8);
            bus.val_in = ($urandom_range(9) < 7);
            bus.hw_in  = HW_W'($urandom_range(127));
            bus.out_rdy = ($urandom_range(9) < 3);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/tdc_sample_accum.md
Name: tdc_sample_accum

Overview:
Post-processing stage directly downstream of the TDC top level. It consumes the pop-count word `hw` and its `val_out` strobe on the capture clock. Over a batch of 2^LOG2_SAMPLES valid samples it accumulates the sum, average, minimum and maximum. The batch result is held for a readout/host interface behind a valid/ready handshake, so single-shot TDC jitter is averaged out before leaving the chip.

Parameters:
- HW_W, 7, width of incoming Hamming-weight word; equals clog2(N)+1 for a 64-tap line.
- LOG2_SAMPLES, 4, log2 of batch size. Batch = 16 samples. Legal range 1..8.
- SUM_W, HW_W+LOG2_SAMPLES, width of the sum accumulator. Derived; must not be overridden.

Ports:
- clk  input  1  capture-domain clock (same clock as the TDC capture/pop-count stage).
- rst  input  1  synchronous, active-high reset.
- en  input  1  global enable; gates sample acceptance only.
- start  input  1  single-cycle pulse; clears accumulators and begins a batch.
- val_in  input  1  sample strobe (TDC val_out).
- hw_in  input  HW_W  sample value (TDC hw).
- out_rdy  input  1  consumer ready.
- out_val  output  1  batch result valid.
- sum_out  output  SUM_W  sum of batch samples.
- avg_out  output  HW_W  sum_out >> LOG2_SAMPLES (truncating).
- min_out  output  HW_W  minimum sample in batch.
- max_out  output  HW_W  maximum sample in batch.
- busy  output  1  high in ACCUM state.
- ovr  output  1  sticky: a valid sample was dropped while a result was held.

Behaviour:
- Reset (rst=1 at posedge): state=IDLE.
  - out_val=0, busy=0, ovr=0, sum_out=0, avg_out=0, min_out=0, max_out=0.
  - Internal count=0, min accumulator = all-ones, max accumulator = 0.
  - rst has priority over every other input.
- "Accepted sample" = state==ACCUM && en && val_in.
- IDLE:
  - Samples are ignored; ovr is not set.
  - start=1 → ACCUM next cycle. Same edge: sum=0, count=0, min=all-ones, max=0, ovr=0.
- ACCUM (busy=1):
  - Each accepted sample, registered at the same edge:
    - sum += hw_in
    - count += 1
    - min = min(min, hw_in)
    - max = max(max, hw_in)
  - When the accepted sample is number 2^LOG2_SAMPLES (count was 2^L−1): go to HOLD. The outputs then reflect the final batch values and out_val=1 on the following cycle. Latency from last accepted sample to out_val = 1 cycle.
  - start=1 in ACCUM restarts the batch: accumulators clear and any sample in that cycle is discarded. Start wins over sample.
  - en=0 stalls counting; state and accumulators hold.
- HOLD (out_val=1):
  - sum_out, avg_out, min_out and max_out are stable until the handshake completes.
  - Any val_in=1 while en=1 sets ovr=1 (sticky). The sample is dropped.
  - Handshake completes when out_val && out_rdy at a posedge.
    - start=0 in that cycle → IDLE, out_val=0.
    - start=1 in that cycle → ACCUM directly, accumulators cleared, ovr cleared, out_val=0.
  - start=1 without out_rdy is ignored; results are never lost.
- Outputs are registered. Output registers update only on entry to HOLD, so they keep the previous batch after the handshake.
- Arithmetic:
  - sum cannot overflow: max = (2^HW_W−1)·2^L fits SUM_W.
  - avg_out = sum_out[SUM_W-1:LOG2_SAMPLES], no rounding.
  - min/max compares are unsigned.
- Batch with all samples equal → min_out == max_out == avg_out.

Test Plan:
1. Reset check: hold rst 2 cycles → all outputs 0, state IDLE. Pulse val_in in IDLE → ovr stays 0, busy stays 0.
2. Basic batch (L=4): start, then 16 back-to-back samples hw=0..15 → out_val rises 1 cycle after the 16th sample, with sum_out=120, avg_out=7, min_out=0, max_out=15. Assert out_rdy → out_val=0 next cycle, state IDLE.
3. Gapped input: 16 samples of hw=32, with en=0 or val_in=0 gaps between them → busy stays high through the gaps. Result: sum_out=512, avg_out=32, min_out=max_out=32.
4. Backpressure/overrun: complete a batch with out_rdy=0 for 10 cycles, driving 3 val_in pulses. Results stay stable and ovr=1. Then assert out_rdy together with start → next cycle busy=1, ovr=0, out_val=0.
5. Restart mid-batch: after 7 samples of hw=64, pulse start. Then 16 samples of hw=1 → sum_out=16, max_out=1. Earlier samples are fully discarded.
6. Reset mid-operation and extremes: assert rst during ACCUM → IDLE with all outputs 0. Then a batch of 16 samples of hw=127 → sum_out=2032, avg_out=127, no width overflow.
